// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter, one grant at a time, rotating priority pointer.
// Latency: grant registered 1 cycle after a qualifying request; at least one IDLE cycle between grants.
// Backpressure: a grantee holds the grant while its req stays high; optional forced revoke under ARB_TIMEOUT_EN.
module rr_arbiter4 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic       pick_vld;
  logic [1:0] pick_id;
  logic [1:0] idx;

  // Reject out-of-range timeout limits at elaboration time.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_cfg
    $error("rr_arbiter4: TIMEOUT_CYCLES must be in 2..255");
  end

  // Rotating priority search: walk from ptr+3 down to ptr so the lowest offset wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr;
    idx      = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  // Counts the cycle number of the current grant; 1 during the first granted cycle.
  logic [7:0] timer;

  // Grant FSM with hold-time limit; revoke behaves like a release plus a one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'd0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timer     <= 8'd0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && pick_vld) begin
            state     <= BUSY;
            gnt       <= 4'b0001 << pick_id;
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
            timer     <= 8'd1;
          end
        end
        BUSY: begin
          if (!req[gnt_id]) begin
            state     <= IDLE;
            gnt       <= 4'd0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 2'd1;
            timer     <= 8'd0;
          end else if (timer == TO_LIMIT) begin
            state     <= IDLE;
            gnt       <= 4'd0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 2'd1;
            timer     <= 8'd0;
            timeout   <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Without the hold-time limit a grant lasts until its requester releases.
  assign timeout = 1'b0;

  // Grant FSM: issue from IDLE when enabled, hold in BUSY until the grantee drops its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'd0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_vld) begin
            state     <= BUSY;
            gnt       <= 4'b0001 << pick_id;
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (!req[gnt_id]) begin
            state     <= IDLE;
            gnt       <= 4'd0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed vectors with hand-computed grants for rr_arbiter4.
// Inputs change 1ns after a rising edge; outputs sampled at the same point and on falling edges.
// Checks grant order, enable gating, async reset and (when built with ARB_TIMEOUT_EN) forced revoke.
module tb_rr_arbiter4;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  rr_arbiter4 #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    if (g[1]) return 2'd1;
    if (g[2]) return 2'd2;
    if (g[3]) return 2'd3;
    return 2'd0;
  endfunction

  // Expected grant state: one-hot vector (0 means no grant).
  task automatic expect_gnt(input string tag, input logic [3:0] g);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_id"}, 32'(gnt_id), 32'(enc(g)));
    chk({tag, "_vld"}, 32'(gnt_valid), 32'(g != 4'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  // Structural invariants on every falling edge.
  always @(negedge clk) begin
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_id_enc", 32'(gnt_id), 32'(enc(gnt)));
    chk("inv_valid", 32'(gnt_valid), 32'(gnt != 4'd0));
`ifndef ARB_TIMEOUT_EN
    chk("inv_timeout0", 32'(timeout), 32'd0);
`endif
  end

  initial begin
    logic [1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    #1;
    expect_gnt("rst", 4'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    expect_gnt("post_rst", 4'd0);

    // Basic grant and one IDLE cycle between grants
    en  = 1'b1;
    req = 4'b0101;
    tick();
    expect_gnt("b_first", 4'b0001);
    req = 4'b0100;
    tick();
    expect_gnt("b_gap", 4'd0);
    tick();
    expect_gnt("b_second", 4'b0100);
    req = 4'd0;
    tick();
    expect_gnt("b_rel", 4'd0);

    // Full rotation with wrap, starting from ptr=0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_gnt("rot_grant", 4'b0001 << seq[i]);
      tick();
      tick();
      expect_gnt("rot_hold", 4'b0001 << seq[i]);
      req[seq[i]] = 1'b0;
      tick();
      expect_gnt("rot_gap", 4'd0);
      req[seq[i]] = 1'b1;
    end
    req = 4'd0;
    tick();
    tick();
    expect_gnt("rot_end", 4'd0);

    // Enable gating
    en  = 1'b0;
    req = 4'b1000;
    tick();
    tick();
    expect_gnt("en_low", 4'd0);
    en = 1'b1;
    tick();
    expect_gnt("en_rise", 4'b1000);
    en = 1'b0;
    tick();
    tick();
    expect_gnt("en_drop_hold", 4'b1000);
    req = 4'd0;
    tick();
    expect_gnt("en_rel", 4'd0);
    req = 4'b1001;
    tick();
    tick();
    expect_gnt("en_no_new", 4'd0);
    req = 4'd0;

    // Asynchronous reset mid-grant, then restart from ptr=0
    en  = 1'b1;
    req = 4'b0010;
    tick();
    expect_gnt("ar_grant", 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    expect_gnt("ar_immediate", 4'd0);
    tick();
    rst = 1'b0;
    req = 4'b0110;
    tick();
    expect_gnt("ar_restart", 4'b0010);
    req = 4'd0;
    tick();
    expect_gnt("ar_rel", 4'd0);

`ifdef ARB_TIMEOUT_EN
    // Forced revoke after TB_TO cycles (ptr=2 here, so requester 0 is first)
    req = 4'b0011;
    tick();
    for (int c = 0; c < TB_TO; c++) begin
      expect_gnt("to_hold", 4'b0001);
      chk("to_nopulse", 32'(timeout), 32'd0);
      if (c < TB_TO - 1) tick();
    end
    tick();
    expect_gnt("to_revoke", 4'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    tick();
    expect_gnt("to_next", 4'b0010);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    // Sole requester is regranted right after its revoke
    req = 4'b0010;
    repeat (TB_TO) tick();
    expect_gnt("to_rev2", 4'd0);
    chk("to_pulse2", 32'(timeout), 32'd1);
    tick();
    expect_gnt("to_regrant", 4'b0010);
    req = 4'd0;
    tick();
`else
    // Grant outlasts any internal limit without the timeout feature
    req = 4'b0001;
    tick();
    for (int c = 0; c < 20; c++) begin
      expect_gnt("nto_hold", 4'b0001);
      chk("nto_timeout", 32'(timeout), 32'd0);
      tick();
    end
    req = 4'd0;
    tick();
    expect_gnt("nto_rel", 4'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum consecutive cycles one grant may be held; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  arbitration enable; when low, no new grant is issued.
REQ-005 req  input  4  request lines; bit i held high while requester i wants the resource.
REQ-006 gnt  output  4  registered one-hot grant; all zero when nothing is granted.
REQ-007 gnt_id  output  2  binary index of the granted requester; 0 when nothing is granted.
REQ-008 gnt_valid  output  1  high while any grant bit is high.
REQ-009 timeout  output  1  one-cycle pulse when a grant is forcibly revoked; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (one grant held).
REQ-011 The block SHALL keep a 2-bit rotating pointer ptr that marks the highest-priority requester; priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-012 In IDLE with en=1 and req!=0, the block SHALL select the first asserted req bit in rotating order and, at the next edge, enter BUSY with gnt, gnt_id and gnt_valid set (1-cycle latency).
REQ-013 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with all outputs zero.
REQ-014 In BUSY, the block SHALL hold gnt unchanged while req[gnt_id]=1, regardless of en or of other req bits.
REQ-015 In BUSY, when req[gnt_id]=0 at an edge, the block SHALL return to IDLE, clear gnt, gnt_id and gnt_valid, and set ptr = gnt_id+1 mod 4.
REQ-016 At least one IDLE cycle SHALL separate two grants; no back-to-back handover.
REQ-017 gnt SHALL never have more than one bit set, and gnt_id SHALL always equal the encoded index of gnt.
REQ-018 When en falls during BUSY, the current grant SHALL continue until release; no new grant follows while en=0.
REQ-019 Request bits that rise and fall while another requester holds the grant SHALL be ignored; no request is latched.
REQ-020 ptr SHALL wrap from 3 to 0.

Reset
REQ-021 While rst=1, the block SHALL force state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, timer=0, immediately and independently of clk.
REQ-022 A reset asserted during BUSY SHALL drop the grant at once; after release, arbitration restarts from ptr=0.

Configuration
REQ-023 With macro ARB_TIMEOUT_EN defined, the block SHALL count cycles in BUSY, and at the edge that would start cycle TIMEOUT_CYCLES+1 of a grant with req[gnt_id] still 1, it SHALL revoke the grant, go to IDLE, set ptr = gnt_id+1 mod 4, and pulse timeout for exactly that cycle.
REQ-024 With ARB_TIMEOUT_EN defined, the revoked requester SHALL be eligible again under normal rotation, including immediate regrant if it is the only requester.
REQ-025 Without ARB_TIMEOUT_EN, the block SHALL have no timer logic, timeout SHALL be constant 0, and grants SHALL last until release.

Verification
REQ-026 Reset, then en=1, req=4'b0101 held: gnt=4'b0001 one cycle later; drop req[0] -> gnt=0 for one cycle, then gnt=4'b0100, gnt_id=2.
REQ-027 en=1, req=4'b1111 held, each grantee drops its bit for one cycle after 3 cycles of grant, then re-raises it: grant sequence is 0,1,2,3,0 with ptr wrap checked.
REQ-028 en=0, req=4'b1000 -> outputs stay 0; raise en -> gnt=4'b1000 next edge; drop en mid-grant -> grant held; release -> no new grant.
REQ-029 Mid-grant on requester 1, assert rst asynchronously between edges -> gnt=0 immediately; after rst falls with req=4'b0110 -> gnt=4'b0010 (ptr=0).
REQ-030 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, req=4'b0011 held -> requester 0 granted for exactly 4 cycles, timeout pulses once, one IDLE cycle, then gnt=4'b0010.
REQ-031 Every test SHALL check on each cycle that gnt is one-hot or zero and that gnt_id matches gnt.
